button_events: RTL and testbench

Converts the four raw push-button inputs into the 5-bit gesture code consumed by the game controller on `input_event`. Synchronises and debounces each button on the 200 Hz gate, tracks one press gesture from first press to full release, and emits a single-cycle event: OR of all buttons touched in bits [3:0] and a long-press flag in bit 4. It sits directly upstream of the game FSM.

---
 rtl/button_events.sv | 121 ++++++++++++
 tb/tb_button_events.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_events.sv
`default_nettype none
// ============================================================================
//  Module      : button_events
//  Description : Synchronises and debounces four push buttons on the 200 Hz
//                gate and reports each press gesture as a single-cycle code.
//  Revision    : 1.0  initial release
// ============================================================================
module button_events #(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int LONG_TICKS     = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       gate_200hz,
    input  logic [3:0] buttons,
    output logic [4:0] input_event,
    output logic       busy
);

    localparam logic [2:0] c_DEBOUNCE_TICKS = 3'(DEBOUNCE_TICKS);
    localparam logic [7:0] c_LONG_TICKS     = 8'(LONG_TICKS);
    localparam logic [7:0] c_DUR_MAX        = 8'hFF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] r_db;
    logic [2:0] r_cnt [4];

    state_t     r_state;
    logic [3:0] r_mask;
    logic [7:0] r_dur;
    logic [4:0] r_event;
    logic       r_busy;

    logic       w_long;

    assign w_long      = (r_dur >= c_LONG_TICKS);
    assign input_event = r_event;
    assign busy        = r_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= buttons;
            r_sync2 <= r_sync1;
        end
    end

    // A new level must persist for DEBOUNCE_TICKS consecutive ticks; any tick
    // that sees the old level again restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_db <= '0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (gate_200hz) begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if ((r_cnt[i] + 3'd1) == c_DEBOUNCE_TICKS) begin
                    r_db[i]  <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 3'd1;
                end
            end
        end
    end

    // Exit on db == 0 takes priority over a coincident tick, so the closing
    // tick never lengthens the reported gesture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_mask  <= '0;
            r_dur   <= '0;
            r_event <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_event <= '0;
                    if (r_db != 4'd0) begin
                        r_state <= HELD;
                        r_busy  <= 1'b1;
                        r_mask  <= r_db;
                        r_dur   <= '0;
                    end
                end
                HELD: begin
                    if (r_db == 4'd0) begin
                        r_event <= {w_long, r_mask};
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_event <= '0;
                        r_mask  <= r_mask | r_db;
                        if (gate_200hz && (r_dur != c_DUR_MAX)) begin
                            r_dur <= r_dur + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_event <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_events.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_events
//  Description : Self-checking bench for button_events: gesture table,
//                hand-written corner sequences and a random run against a model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_button_events;

    localparam int c_DEB  = 4;
    localparam int c_LONG = 100;

    logic       clk;
    logic       reset;
    logic       gate_200hz;
    logic [3:0] buttons;
    logic [4:0] input_event;
    logic       busy;

    int errors;
    int checks;

    // Reference model state
    logic [3:0] m_s1, m_s2, m_db;
    int         m_run [4];
    logic       m_active;
    logic [3:0] m_mask;
    int         m_dur;
    logic [4:0] m_ev;

    // Bench bookkeeping
    logic       tb_rst;
    int         ev_count;
    int         busy_seen;
    int         gate_count;
    logic [4:0] last_event;

    button_events #(
        .DEBOUNCE_TICKS(c_DEB),
        .LONG_TICKS    (c_LONG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .gate_200hz (gate_200hz),
        .buttons    (buttons),
        .input_event(input_event),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_active = 1'b0; m_mask = '0; m_dur = 0; m_ev = '0;
    endtask

    // One clock of the gesture rules: the gesture sees the debounced level from
    // before this edge, the debouncer sees the synchronised level from before it.
    task automatic model_step(input logic [3:0] b, input logic g);
        logic [3:0] old_db;
        logic [3:0] old_s2;
        old_db = m_db;
        old_s2 = m_s2;
        if (!m_active) begin
            m_ev = '0;
            if (old_db != 0) begin
                m_active = 1'b1; m_mask = old_db; m_dur = 0;
            end
        end else if (old_db == 0) begin
            m_ev = {(m_dur >= c_LONG), m_mask};
            m_active = 1'b0;
        end else begin
            m_ev = '0;
            m_mask = m_mask | old_db;
            if (g) m_dur = (m_dur + 1 > 255) ? 255 : m_dur + 1;
        end
        if (g) begin
            for (int i = 0; i < 4; i++) begin
                if (old_s2[i] == m_db[i]) m_run[i] = 0;
                else begin
                    m_run[i]++;
                    if (m_run[i] == c_DEB) begin
                        m_db[i] = old_s2[i];
                        m_run[i] = 0;
                    end
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = b;
    endtask

    task automatic cyc(input logic [3:0] b, input logic g);
        @(negedge clk);
        buttons = b; gate_200hz = g; reset = tb_rst;
        @(posedge clk);
        if (reset) model_reset();
        else model_step(b, g);
        if (g) gate_count++;
        #1;
        chk("model_cycle", {27'd0, busy, input_event}, {27'd0, m_active, m_ev});
        if (input_event != 0) begin
            ev_count++;
            last_event = input_event;
        end
        if (busy) busy_seen++;
    endtask

    task automatic hold(input logic [3:0] b, input int nticks, input int per);
        for (int t = 0; t < nticks; t++)
            for (int c = 0; c < per; c++)
                cyc(b, c == per - 1);
    endtask

    typedef struct {
        logic [3:0] pat;
        int         ticks;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int ev0, n, g0;
        logic found;

        errors = 0; checks = 0;
        ev_count = 0; busy_seen = 0; gate_count = 0; last_event = '0;
        buttons = '0; gate_200hz = 1'b0;
        tb_rst = 1'b1; reset = 1'b1;
        model_reset();

        vecs[0] = '{4'b0001,  40, 5'b00001};
        vecs[1] = '{4'b0100, 120, 5'b10100};
        vecs[2] = '{4'b1000, 300, 5'b11000};
        vecs[3] = '{4'b0010,  60, 5'b00010};
        vecs[4] = '{4'b0011,  50, 5'b00011};
        vecs[5] = '{4'b1111, 150, 5'b11111};

        hold(4'b0000, 3, 1);
        chk("reset_event", {27'd0, input_event}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        tb_rst = 1'b0;
        hold(4'b0000, 4, 1);

        // Back-to-back ticks give exact latencies: 2 sync clocks + 4 ticks + 1.
        n = 0; found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cyc(4'b0001, 1'b1); n++;
            if (busy) found = 1'b1;
        end
        chk("press_latency", n, 7);
        hold(4'b0001, 20, 1);
        ev0 = ev_count; n = 0; found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cyc(4'b0000, 1'b1); n++;
            if (input_event != 0) found = 1'b1;
        end
        chk("release_latency", n, 7);
        chk("release_code", {27'd0, input_event}, 32'h01);
        cyc(4'b0000, 1'b1);
        chk("event_width", {27'd0, input_event}, 32'd0);
        chk("event_count_fast", ev_count - ev0, 1);

        for (int v = 0; v < 6; v++) begin
            ev0 = ev_count;
            hold(vecs[v].pat, vecs[v].ticks, 4);
            hold(4'b0000, 15, 4);
            chk("table_count", ev_count - ev0, 1);
            chk("table_code", {27'd0, last_event}, {27'd0, vecs[v].exp});
        end

        // Red added green after 10 ticks, both released at 50.
        ev0 = ev_count;
        hold(4'b0001, 10, 4);
        hold(4'b0011, 40, 4);
        hold(4'b0000, 15, 4);
        chk("add_green_count", ev_count - ev0, 1);
        chk("add_green_code", {27'd0, last_event}, 32'h03);

        // Yellow released and re-pressed inside one red gesture.
        ev0 = ev_count;
        hold(4'b1001, 10, 4);
        hold(4'b0001, 10, 4);
        hold(4'b1001, 10, 4);
        hold(4'b0000, 15, 4);
        chk("repress_count", ev_count - ev0, 1);
        chk("repress_code", {27'd0, last_event}, 32'h09);

        // Single-tick glitches never reach the debounced level.
        ev0 = ev_count; busy_seen = 0;
        for (int t = 0; t < 20; t++) hold((t % 2 == 0) ? 4'b0001 : 4'b0000, 1, 4);
        hold(4'b0000, 10, 4);
        chk("bounce_events", ev_count - ev0, 0);
        chk("bounce_busy", busy_seen, 0);

        // Asynchronous reset in the middle of a green gesture.
        hold(4'b0010, 60, 4);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        @(negedge clk); #2;
        reset = 1'b1; tb_rst = 1'b1;
        model_reset();
        #1;
        chk("async_reset_busy", {31'd0, busy}, 32'd0);
        chk("async_reset_event", {27'd0, input_event}, 32'd0);
        ev0 = ev_count;
        hold(4'b0010, 2, 4);
        tb_rst = 1'b0;
        g0 = gate_count; n = -1;
        for (int t = 0; t < 10 && n < 0; t++)
            for (int c = 0; c < 4 && n < 0; c++) begin
                cyc(4'b0010, c == 3);
                if (busy) n = gate_count - g0;
            end
        chk("post_reset_busy_ticks", n, 4);
        hold(4'b0010, 110, 4);
        hold(4'b0000, 15, 4);
        chk("post_reset_count", ev_count - ev0, 1);
        chk("post_reset_code", {27'd0, last_event}, 32'h12);

        // Random gestures checked cycle by cycle against the model.
        for (int s = 0; s < 40; s++) begin
            int len, per;
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 140)) : int'($urandom_range(1, 12));
            per = int'($urandom_range(1, 4));
            hold(4'($urandom_range(0, 15)), len, per);
        end
        hold(4'b0000, 20, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
